// File: rtl/ysyx_25020047_ifu.sv
// ysyx_25020047_ifu: single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/DRAIN/HOLD).
// Define YSYX_25020047_IFU_TIMEOUT_EN to build the WAIT/DRAIN watchdog limited by TIMEOUT_CYCLES.
module ysyx_25020047_ifu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err,
  output logic        timeout
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;
  state_t state, state_d;
  logic [31:0] addr_q;
  logic take, ld_rsp, to_hit;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_range
    $error("TIMEOUT_CYCLES must be within 1..255");
  end
  assign take = state == IDLE && fetch_en && !flush;
  assign imem_req_valid = state == REQ;
  assign imem_req_addr = addr_q;
  assign inst_valid = state == HOLD;
`ifdef YSYX_25020047_IFU_TIMEOUT_EN
  logic [7:0] cnt;
  // A flush in WAIT wins over an expiring watchdog; DRAIN ignores flush.
  assign to_hit = !imem_rsp_valid && cnt == 8'(TIMEOUT_CYCLES - 1) &&
                  (state == DRAIN || (state == WAIT && !flush));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_hit;
      cnt <= (state_d != state && (state_d == WAIT || state_d == DRAIN)) ? 8'd0 :
             ((state == WAIT || state == DRAIN) && !imem_rsp_valid) ? cnt + 8'd1 : cnt;
    end
  end
`else
  assign to_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state;
    ld_rsp = 1'b0;
    case (state)
      IDLE: state_d = !take ? IDLE : |pc[1:0] ? HOLD : REQ;
      REQ: state_d = flush ? IDLE : imem_req_ready ? WAIT : REQ;
      WAIT: begin
        state_d = flush ? (imem_rsp_valid ? IDLE : DRAIN) : (imem_rsp_valid || to_hit) ? HOLD : WAIT;
        ld_rsp = !flush && imem_rsp_valid;
      end
      DRAIN: state_d = (imem_rsp_valid || to_hit) ? IDLE : DRAIN;
      HOLD: state_d = (flush || inst_ready) ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      inst <= '0;
      inst_pc <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_d;
      if (take) addr_q <= pc;
      if (take && |pc[1:0]) begin
        inst <= '0;
        inst_pc <= pc;
        fetch_err <= 1'b1;
      end
      if (ld_rsp) begin
        inst <= imem_rsp_data;
        inst_pc <= addr_q;
        fetch_err <= imem_rsp_err;
      end
      if (to_hit && state == WAIT) begin
        inst <= '0;
        inst_pc <= addr_q;
        fetch_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// tb_ysyx_25020047_ifu: directed bench with a transaction-level fetch model checked every cycle.
module tb_ysyx_25020047_ifu;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] pc = '0, imem_req_addr, imem_rsp_data = '0, inst, inst_pc;
  logic fetch_en = 0, flush = 0, imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic imem_rsp_err = 0, inst_valid, inst_ready = 0, fetch_err, timeout;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  ysyx_25020047_ifu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_err(fetch_err), .timeout(timeout)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  // Model: one fetch transaction tracked as offered / outstanding / draining / delivered.
  bit m_on, m_req, m_wait, m_drain, m_hold, m_to;
  logic [31:0] m_addr, m_inst, m_pc;
  logic m_err;
  int m_n;
  always @(posedge clk) begin
    m_to = 0;
    if (rst) begin
      m_on = 1; m_req = 0; m_wait = 0; m_drain = 0; m_hold = 0;
    end else if (m_hold) begin
      m_hold = !(flush || inst_ready);
    end else if (m_req) begin
      if (flush) m_req = 0;
      else if (imem_req_ready) begin m_req = 0; m_wait = 1; m_n = 0; end
    end else if (m_wait) begin
      if (flush) begin
        m_wait = 0; m_drain = !imem_rsp_valid; m_n = 0;
      end else if (imem_rsp_valid) begin
        m_wait = 0; m_hold = 1; m_inst = imem_rsp_data; m_err = imem_rsp_err; m_pc = m_addr;
      end else begin
        m_n++;
`ifdef YSYX_25020047_IFU_TIMEOUT_EN
        if (m_n == TO) begin m_wait = 0; m_hold = 1; m_inst = 0; m_err = 1; m_pc = m_addr; m_to = 1; end
`endif
      end
    end else if (m_drain) begin
      if (imem_rsp_valid) m_drain = 0;
      else begin
        m_n++;
`ifdef YSYX_25020047_IFU_TIMEOUT_EN
        if (m_n == TO) begin m_drain = 0; m_to = 1; end
`endif
      end
    end else if (fetch_en && !flush) begin
      m_addr = pc;
      if (pc[1:0] != 0) begin m_hold = 1; m_inst = 0; m_err = 1; m_pc = pc; end
      else m_req = 1;
    end
  end
  always @(negedge clk) if (m_on) begin
    check("req_valid", imem_req_valid, 32'(m_req));
    if (m_req) check("req_addr", imem_req_addr, m_addr);
    check("inst_valid", inst_valid, 32'(m_hold));
    if (m_hold) begin
      check("inst", inst, m_inst);
      check("inst_pc", inst_pc, m_pc);
      check("fetch_err", fetch_err, 32'(m_err));
    end
    check("timeout", timeout, 32'(m_to));
  end
  task automatic fetch(input logic [31:0] a, input int rdly, input int sdly,
                       input logic [31:0] d, input logic e, input int hdly);
    pc = a; fetch_en = 1; cyc();
    fetch_en = 0; pc = ~a;
    repeat (rdly) begin check("hold_req_valid", imem_req_valid, 1); cyc(); end
    imem_req_ready = 1; cyc();
    imem_req_ready = 0;
    repeat (sdly) cyc();
    imem_rsp_valid = 1; imem_rsp_data = d; imem_rsp_err = e; cyc();
    imem_rsp_valid = 0; imem_rsp_data = '1; imem_rsp_err = 0;
    check("got_inst", inst, d); check("got_pc", inst_pc, a); check("got_err", fetch_err, 32'(e));
    fetch_en = hdly > 0; pc = 32'h1234_5678;
    repeat (hdly) begin cyc(); check("held_valid", inst_valid, 1); check("held_inst", inst, d); end
    fetch_en = 0; inst_ready = 1; cyc();
    inst_ready = 0;
    check("released", inst_valid, 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 0); check({tag, "_req_addr"}, imem_req_addr, 0);
    check({tag, "_inst_valid"}, inst_valid, 0); check({tag, "_inst"}, inst, 0);
    check({tag, "_inst_pc"}, inst_pc, 0); check({tag, "_err"}, fetch_err, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask
  initial begin
    repeat (2) cyc();
    rst = 0;
    check_zero("rst");
    pc = 32'h8000_0000; fetch_en = 1; imem_req_ready = 1; cyc();
    fetch_en = 0; pc = '0;
    check("c1_req_valid", imem_req_valid, 1); check("c1_req_addr", imem_req_addr, 32'h8000_0000);
    cyc();
    check("c2_req_valid", imem_req_valid, 0);
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0010_0093; cyc();
    imem_rsp_valid = 0; imem_rsp_data = '0;
    check("c3_valid", inst_valid, 1); check("c3_inst", inst, 32'h0010_0093);
    check("c3_pc", inst_pc, 32'h8000_0000); check("c3_err", fetch_err, 0);
    inst_ready = 1; cyc();
    inst_ready = 0;
    fetch(32'h8000_0010, 3, 1, 32'h0000_0013, 0, 5);
    pc = 32'h8000_0002; fetch_en = 1; cyc();
    fetch_en = 0;
    check("mis_req", imem_req_valid, 0); check("mis_valid", inst_valid, 1);
    check("mis_err", fetch_err, 1); check("mis_inst", inst, 0);
    inst_ready = 1; cyc();
    inst_ready = 0;
    pc = 32'h8000_0020; fetch_en = 1; imem_req_ready = 1; cyc();
    fetch_en = 0; cyc();
    imem_req_ready = 0; flush = 1; cyc();
    flush = 0; cyc();
    flush = 1; cyc();
    flush = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hBAD0_BAD0; cyc();
    imem_rsp_valid = 0;
    check("drain_no_valid", inst_valid, 0);
    fetch(32'h8000_0024, 0, 0, 32'h0020_0113, 0, 0);
    fetch(32'h8000_0028, 0, 2, 32'hDEAD_BEEF, 1, 0);
    pc = 32'h8000_0030; fetch_en = 1; imem_req_ready = 1; cyc();
    fetch_en = 0; cyc();
    imem_req_ready = 0; imem_rsp_valid = 1; flush = 1; cyc();
    imem_rsp_valid = 0; flush = 0;
    check("fr_valid", inst_valid, 0); check("fr_req", imem_req_valid, 0);
    cyc();
    check("fr_valid2", inst_valid, 0);
    pc = 32'h8000_0034; fetch_en = 1; cyc();
    fetch_en = 0; imem_req_ready = 1; flush = 1; cyc();
    imem_req_ready = 0; flush = 0;
    check("req_flush", imem_req_valid, 0);
    cyc();
    pc = 32'h8000_0038; fetch_en = 1; imem_req_ready = 1; cyc();
    fetch_en = 0; cyc();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0030_0193; cyc();
    imem_rsp_valid = 0; flush = 1; inst_ready = 1; cyc();
    flush = 0; inst_ready = 0;
    check("hold_flush", inst_valid, 0);
`ifdef YSYX_25020047_IFU_TIMEOUT_EN
    pc = 32'h8000_0050; fetch_en = 1; imem_req_ready = 1; cyc();
    fetch_en = 0; cyc();
    imem_req_ready = 0;
    for (int i = 1; i <= TO; i++) begin cyc(); check("to_pulse", timeout, 32'(i == TO)); end
    check("to_valid", inst_valid, 1); check("to_err", fetch_err, 1);
    check("to_inst", inst, 0); check("to_pc", inst_pc, 32'h8000_0050);
    cyc();
    check("to_one_cycle", timeout, 0);
    inst_ready = 1; cyc();
    inst_ready = 0;
`endif
    pc = 32'h8000_0040; fetch_en = 1; imem_req_ready = 1; cyc();
    fetch_en = 0; cyc();
    imem_req_ready = 0; rst = 1; cyc();
    rst = 0;
    check_zero("wrst");
    fetch(32'h8000_0044, 1, 0, 32'h0040_0213, 0, 1);
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
